// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types for the ALU macro-op sequencer
package alu_seq_pkg;
  localparam int DATA_W = 8;
  localparam int CNT_W = 16;
  localparam int MAX_STEPS = 4;
  localparam int STEP_W = $clog2(MAX_STEPS);
  typedef enum logic [1:0] {CMD_ADD = 2'b00, CMD_ROR = 2'b01, CMD_NAND = 2'b10, CMD_PASS = 2'b11} alu_cmd_e;
  typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ROR, OP_NOT, OP_PASS} macro_op_e;
  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DONE} seq_state_e;
  typedef enum logic [2:0] {SRC_RA, SRC_RB, SRC_T, SRC_U, SRC_ONE, SRC_ZERO} src_sel_e;
  typedef enum logic [1:0] {DST_R, DST_T, DST_U, DST_RA} dst_sel_e;
  typedef struct packed {
    alu_cmd_e cmd;
    src_sel_e src_a;
    src_sel_e src_b;
    dst_sel_e dst;
    logic last;
  } uop_t;
  function automatic uop_t mk(alu_cmd_e c, src_sel_e a, src_sel_e b, dst_sel_e d, logic l);
    return '{cmd: c, src_a: a, src_b: b, dst: d, last: l};
  endfunction
endpackage

// File: rtl/alu_seq_ucode.sv
// alu_seq_ucode: microcode ROM mapping (op, step) to one ALU primitive
module alu_seq_ucode
  import alu_seq_pkg::*;
(
  input  logic [2:0]        op,
  input  logic [STEP_W-1:0] step,
  output uop_t              uop
);
  always_comb begin
    uop = mk(CMD_PASS, SRC_ZERO, SRC_ZERO, DST_R, 1'b1);
    case ({op, step})
      {OP_ADD,  2'd0}: uop = mk(CMD_ADD,  SRC_RA,   SRC_RB, DST_R,  1'b1);
      {OP_ROR,  2'd0}: uop = mk(CMD_ROR,  SRC_RA,   SRC_RB, DST_R,  1'b1);
      {OP_PASS, 2'd0}: uop = mk(CMD_PASS, SRC_ZERO, SRC_RB, DST_R,  1'b1);
      {OP_NOT,  2'd0}: uop = mk(CMD_NAND, SRC_RA,   SRC_RA, DST_R,  1'b1);
      {OP_AND,  2'd0}: uop = mk(CMD_NAND, SRC_RA,   SRC_RB, DST_T,  1'b0);
      {OP_AND,  2'd1}: uop = mk(CMD_NAND, SRC_T,    SRC_T,  DST_R,  1'b1);
      {OP_OR,   2'd0}: uop = mk(CMD_NAND, SRC_RA,   SRC_RA, DST_T,  1'b0);
      {OP_OR,   2'd1}: uop = mk(CMD_NAND, SRC_RB,   SRC_RB, DST_U,  1'b0);
      {OP_OR,   2'd2}: uop = mk(CMD_NAND, SRC_T,    SRC_U,  DST_R,  1'b1);
      {OP_SUB,  2'd0}: uop = mk(CMD_NAND, SRC_RB,   SRC_RB, DST_T,  1'b0);
      {OP_SUB,  2'd1}: uop = mk(CMD_ADD,  SRC_RA,   SRC_T,  DST_T,  1'b0);
      {OP_SUB,  2'd2}: uop = mk(CMD_ADD,  SRC_T,    SRC_ONE, DST_R, 1'b1);
      {OP_XOR,  2'd0}: uop = mk(CMD_NAND, SRC_RA,   SRC_RB, DST_T,  1'b0);
      {OP_XOR,  2'd1}: uop = mk(CMD_NAND, SRC_RA,   SRC_T,  DST_U,  1'b0);
      {OP_XOR,  2'd2}: uop = mk(CMD_NAND, SRC_RB,   SRC_T,  DST_RA, 1'b0);
      {OP_XOR,  2'd3}: uop = mk(CMD_NAND, SRC_U,    SRC_RA, DST_R,  1'b1);
      default: ;
    endcase
  end
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: expands 8 macro ops into 1-4 primitive ALU cycles
// ALU_SEQ_PERF_EN adds a saturating busy-cycle counter output perf_busy.
module alu_op_sequencer
  import alu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_parity,
  output logic              rsp_zero,
  output logic [1:0]        alu_cmd,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_rslt,
  input  logic              alu_pari
`ifdef ALU_SEQ_PERF_EN
  ,output logic [CNT_W-1:0] perf_busy
`endif
);
  seq_state_e state, state_nxt;
  logic [2:0] op;
  logic [STEP_W-1:0] step;
  logic [DATA_W-1:0] ra, rb, t, u;
  logic exec;
  uop_t uop;

  alu_seq_ucode u_ucode (.op(op), .step(step), .uop(uop));

  function automatic logic [DATA_W-1:0] pick(src_sel_e s, logic [DATA_W-1:0] a, b, c, d);
    return s == SRC_RA ? a : s == SRC_RB ? b : s == SRC_T ? c : s == SRC_U ? d :
           s == SRC_ONE ? DATA_W'(1) : '0;
  endfunction

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else state <= state_nxt;

  always_comb begin
    exec = state == ST_EXEC;
    state_nxt = state == ST_IDLE ? (req_valid ? ST_EXEC : ST_IDLE) :
                exec ? (uop.last ? ST_DONE : ST_EXEC) :
                (rsp_ready ? ST_IDLE : ST_DONE);
    req_ready = state == ST_IDLE;
    rsp_valid = state == ST_DONE;
    alu_cmd = exec ? uop.cmd : CMD_PASS;
    alu_a = exec ? pick(uop.src_a, ra, rb, t, u) : '0;
    alu_b = exec ? pick(uop.src_b, ra, rb, t, u) : '0;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op <= '0;
      step <= '0;
      {ra, rb, t, u} <= '0;
      rsp_data <= '0;
      rsp_parity <= 1'b0;
      rsp_zero <= 1'b0;
    end else if (state == ST_IDLE && req_valid) begin
      op <= req_op;
      ra <= req_op == OP_ROR ? req_a & 8'h07 : req_a;
      rb <= req_b;
      step <= '0;
    end else if (exec) begin
      step <= step + 1'b1;
      case (uop.dst)
        DST_T:  t <= alu_rslt;
        DST_U:  u <= alu_rslt;
        DST_RA: ra <= alu_rslt;
        DST_R: begin
          rsp_data <= alu_rslt;
          rsp_parity <= alu_pari;
          rsp_zero <= alu_rslt == '0;
        end
      endcase
    end

`ifdef ALU_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) perf_busy <= '0;
    else if (state != ST_IDLE && perf_busy != '1) perf_busy <= perf_busy + 1'b1;
`endif
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed vectors plus reset/stall corner sequences
module tb_alu_op_sequencer;
  logic clk = 0, rst_n = 0;
  logic req_valid = 0, req_ready, rsp_valid, rsp_ready = 0;
  logic [2:0] req_op = 0;
  logic [7:0] req_a = 0, req_b = 0, rsp_data, alu_a, alu_b, alu_rslt;
  logic rsp_parity, rsp_zero, alu_pari;
  logic [1:0] alu_cmd;
  logic [15:0] rr;
`ifdef ALU_SEQ_PERF_EN
  logic [15:0] perf_busy;
`endif
  int n_cmp = 0, n_err = 0;
  logic [7:0] cmd_hist, first_a;

  alu_op_sequencer dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_parity(rsp_parity),
    .rsp_zero(rsp_zero), .alu_cmd(alu_cmd), .alu_a(alu_a), .alu_b(alu_b),
    .alu_rslt(alu_rslt), .alu_pari(alu_pari)
`ifdef ALU_SEQ_PERF_EN
    , .perf_busy(perf_busy)
`endif
  );

  always #5 clk = ~clk;

  // Reference model of the combinational ALU the sequencer drives
  always_comb begin
    rr = {alu_b, alu_b} >> alu_a[2:0];
    alu_rslt = alu_cmd == 2'b00 ? alu_a + alu_b : alu_cmd == 2'b01 ? rr[7:0] :
               alu_cmd == 2'b10 ? ~(alu_a & alu_b) : alu_b;
    alu_pari = ^alu_rslt;
  end

  typedef struct {
    logic [2:0] op;
    logic [7:0] a, b, d;
    logic p, z;
    int n, hold;
  } vec_t;
  vec_t v[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t x);
    int cnt;
    cmd_hist = '0;
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1; req_op = x.op; req_a = x.a; req_b = x.b;
    rsp_ready = x.hold == 0;
    @(negedge clk);
    req_valid = 0; req_a = ~x.a; req_b = ~x.b; req_op = ~x.op;
    first_a = alu_a;
    cnt = 0;
    while (!rsp_valid && cnt < 10) begin
      cmd_hist = {cmd_hist[5:0], alu_cmd};
      @(negedge clk);
      cnt++;
    end
    chk("latency", cnt, x.n);
    chk("rsp_data", rsp_data, x.d);
    chk("rsp_parity", rsp_parity, x.p);
    chk("rsp_zero", rsp_zero, x.z);
    chk("req_ready_done", req_ready, 0);
    chk("alu_cmd_done", alu_cmd, 2'b11);
    chk("alu_a_done", alu_a, 0);
    for (int i = 0; i < x.hold; i++) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_data", {rsp_data, rsp_zero}, {x.d, x.z});
      chk("hold_ready", req_ready, 0);
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    chk("idle_after", req_ready, 1);
    chk("valid_drop", rsp_valid, 0);
  endtask

  initial begin
    int seen;
    v[0] = '{3'd1, 8'h05, 8'h07, 8'hFE, 1'b1, 1'b0, 3, 0};
    v[1] = '{3'd4, 8'hA5, 8'h0F, 8'hAA, 1'b0, 1'b0, 4, 0};
    v[2] = '{3'd5, 8'h0B, 8'h81, 8'h30, 1'b0, 1'b0, 1, 0};
    v[3] = '{3'd3, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 3, 3};
    v[4] = '{3'd0, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 1, 0};
    v[5] = '{3'd2, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 2, 0};
    v[6] = '{3'd6, 8'h5A, 8'h00, 8'hA5, 1'b0, 1'b0, 1, 0};
    v[7] = '{3'd7, 8'h11, 8'h80, 8'h80, 1'b1, 1'b0, 1, 0};
    v[8] = '{3'd3, 8'h0C, 8'h30, 8'h3C, 1'b0, 1'b0, 3, 0};
    v[9] = '{3'd0, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b1, 1, 0};
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_out", {rsp_data, rsp_parity, rsp_zero}, 0);
    chk("rst_alu", {alu_cmd, alu_a, alu_b}, 18'h30000);
    rst_n = 1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      run_op(v[i]);
      if (i == 1) chk("xor_cmds", cmd_hist, 8'hAA);
      if (i == 2) chk("ror_alu_a", first_a, 8'h03);
    end
    // XOR dropped by a reset pulse in its second EXEC step
    req_valid = 1; req_op = 3'd4; req_a = 8'hA5; req_b = 8'h0F; rsp_ready = 1;
    @(negedge clk);
    req_valid = 0;
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("midrst_ready", req_ready, 1);
    chk("midrst_alu", {alu_cmd, alu_a, alu_b}, 18'h30000);
    @(negedge clk);
    rst_n = 1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("midrst_no_rsp", seen, 0);
    rsp_ready = 0;
    run_op(v[9]);
`ifdef ALU_SEQ_PERF_EN
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("perf_reset", perf_busy, 0);
    run_op(v[6]);
    run_op(v[5]);
    chk("perf_busy", perf_busy, 5);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Multi-cycle microsequencer in front of the combinational 8-bit ALU. The ALU supports only four primitives: add, rotate-right, NAND, pass-B.
- Accepts one 8-op macro request over a valid/ready handshake and drives the ALU for 1-4 cycles, keeping intermediates in local temps.
- Returns result plus parity/zero flags over a second valid/ready handshake.
- Sits between instruction decode and the ALU. It is the sole driver of the ALU's cmd/operand inputs.

Parameters:
- DATA_W, 8, datapath width; fixed by the ALU, not for override.
- CNT_W, 16, width of the optional busy-cycle counter.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request valid
- req_ready  output  1  sequencer can accept a request
- req_op  input  3  macro op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 ROR, 6 NOT, 7 PASS
- req_a  input  8  operand A (ROR: rotate amount, bits [2:0] used)
- req_b  input  8  operand B
- rsp_valid  output  1  response valid
- rsp_ready  input  1  consumer accepts response
- rsp_data  output  8  result
- rsp_parity  output  1  XOR-reduction of result
- rsp_zero  output  1  result == 0
- alu_cmd  output  2  to ALU: 00 add, 01 ror (rotates inB by inA), 10 NAND, 11 pass B
- alu_a  output  8  to ALU inA
- alu_b  output  8  to ALU inB
- alu_rslt  input  8  from ALU
- alu_pari  input  1  from ALU parity

Behaviour:
- Reset (async, rst_n low):
  - State = IDLE; req_ready = 1.
  - rsp_valid, rsp_data, rsp_parity and rsp_zero = 0.
  - alu_cmd = 11; alu_a = alu_b = 0.
  - All temps (RA, RB, T, U) = 0; step = 0.
- States: IDLE -> EXEC -> DONE -> IDLE.
- IDLE:
  - req_ready = 1.
  - On req_valid: latch op, RA, RB; step = 0; go to EXEC.
  - ROR masks RA to RA & 8'h07 at latch.
- EXEC:
  - One ALU primitive per cycle; ALU result is captured at the clock edge ending that cycle.
  - Step programs (dest <- cmd(inA, inB)):
    - ADD: R <- add(RA, RB).
    - ROR: R <- ror(RA, RB).
    - PASS: R <- pass(0, RB).
    - NOT: R <- nand(RA, RA).
    - AND: T <- nand(RA, RB); R <- nand(T, T).
    - OR: T <- nand(RA, RA); U <- nand(RB, RB); R <- nand(T, U).
    - SUB: T <- nand(RB, RB); T <- add(RA, T); R <- add(T, 8'h01).
    - XOR: T <- nand(RA, RB); U <- nand(RA, T); RA <- nand(RB, T); R <- nand(U, RA).
  - Step counts: 1, 1, 1, 1, 2, 3, 3, 4.
  - On the last step: rsp_data = alu_rslt, rsp_parity = alu_pari, rsp_zero = (alu_rslt == 0); go to DONE.
- Latency: request accepted at edge k; rsp_valid rises at edge k+N, where N = step count.
- DONE:
  - rsp_valid = 1; response outputs held stable until rsp_valid && rsp_ready, then go to IDLE.
  - req_ready = 0 in EXEC and DONE; no overlap.
  - Earliest next accept is the cycle after the response handshake.
- ALU outputs outside EXEC: cmd = 11, operands = 0.
- Arithmetic: all 8-bit modulo 2^8; carry is discarded (ADD FF+01 = 00).
- Reset asserted mid-EXEC or mid-DONE: the in-flight op is dropped silently and no response is produced.
- req_valid low or X in EXEC/DONE is ignored.

Optional Feature:
- Macro: ALU_SEQ_PERF_EN.
- Defined:
  - Adds output perf_busy, width CNT_W.
  - Counts cycles with state != IDLE; saturates at all-ones.
  - Cleared by reset only.
- Undefined: no port and no counter logic.

Decomposition:
- Package alu_seq_pkg holds:
  - enum alu_cmd_e (ADD = 00, ROR = 01, NAND = 10, PASS = 11).
  - enum macro_op_e (3-bit encodings above).
  - enum seq_state_e (IDLE, EXEC, DONE).
  - enum operand-source select (RA, RB, T, U, ONE, ZERO).
  - enum destination select.
  - Localparam MAX_STEPS = 4.
- Sub-module alu_seq_ucode: combinational microcode ROM mapping (op, step) -> {cmd, srcA, srcB, dest, last}.

Test Plan:
- SUB, A = 05, B = 07, rsp_ready = 1 -> rsp_data FE, parity 1, zero 0; rsp_valid exactly 3 cycles after the accept edge.
- XOR, A = A5, B = 0F -> AA, parity 0, zero 0; 4 EXEC cycles observed on alu_cmd: 10, 10, 10, 10.
- ROR, A = 0B (masked to 3), B = 81 -> 30, parity 0; alu_a = 03 during EXEC.
- OR, A = 00, B = 00, with rsp_ready low 3 cycles -> rsp_data 00 / zero 1 held stable; req_ready 0 throughout; IDLE the cycle after the handshake.
- XOR accepted, rst_n pulsed low during step 2, then ADD FF + 01 -> no XOR response; ADD returns 00, zero 1, parity 0.
- With ALU_SEQ_PERF_EN: back-to-back NOT then AND, each response accepted on the first DONE cycle -> perf_busy = 5.
